// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared state encodings, parity modes and the parity helper
// used by the UART echo core.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;
  localparam int   MAX_WORD_BITS    = 9;

  // Parity bit for a word zero-extended to MAX_WORD_BITS; zero padding leaves the XOR unchanged.
  function automatic logic word_parity(input logic [MAX_WORD_BITS-1:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, head word shown combinationally on rdata,
// a read pops it. Writes when full and reads when empty are ignored.
module uart_sync_fifo #(
  parameter int WORD_BITS      = 8,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    write,
  input  logic                    read,
  input  logic [WORD_BITS-1:0]    wdata,
  output logic [WORD_BITS-1:0]    rdata,
  output logic                    full,
  output logic                    empty,
  output logic [FIFO_ADDR_BITS:0] level
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_L = (FIFO_ADDR_BITS+1)'(DEPTH);

  logic [WORD_BITS-1:0]      mem_r [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_r;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_r;
  logic [FIFO_ADDR_BITS:0]   level_r;
  logic                      wr_en_s;
  logic                      rd_en_s;

  assign full    = (level_r == DEPTH_L);
  assign empty   = (level_r == '0);
  assign wr_en_s = write & ~full;
  assign rd_en_s = read & ~empty;
  assign rdata   = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Storage array, no reset needed since level gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_core.sv
// uart_echo_core: oversampling UART receiver and transmitter joined by an echo FIFO.
// Define UART_ECHO_PARITY_EN to add a parity bit (type set by PARITY_ODD) in both directions.
module uart_echo_core
  import uart_echo_pkg::*;
#(
  parameter int WORD_BITS      = 8,
  parameter int OVERSAMPLE     = 16,
  parameter int BAUD_DIV       = 651,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int PARITY_ODD     = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rx_i,
  output logic                    tx_o,
  input  logic                    echo_en_i,
  input  logic                    tx_en_i,
  input  logic                    clear_err_i,
  output logic [WORD_BITS-1:0]    rx_data_o,
  output logic                    rx_valid_o,
  output logic                    tx_busy_o,
  output logic [FIFO_ADDR_BITS:0] fifo_level_o,
  output logic                    overrun_o,
  output logic                    frame_err_o,
  output logic                    parity_err_o
);

`ifdef UART_ECHO_PARITY_EN
  localparam logic HAS_PARITY = 1'b1;
`else
  localparam logic HAS_PARITY = 1'b0;
`endif

  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam int   BW       = $clog2(BAUD_DIV);
  localparam int   TCW      = $clog2(2*OVERSAMPLE+1);
  localparam int   BCW      = $clog2(WORD_BITS+1);

  localparam logic [BW-1:0]  BAUD_LAST  = BW'(BAUD_DIV-1);
  localparam logic [TCW-1:0] HALF_LAST  = TCW'(OVERSAMPLE/2-1);
  localparam logic [TCW-1:0] BIT_LAST   = TCW'(OVERSAMPLE-1);
  localparam logic [TCW-1:0] START_LAST = TCW'(OVERSAMPLE);
  localparam logic [TCW-1:0] STOP_LAST  = TCW'(STOP_BITS*OVERSAMPLE-1);
  localparam logic [BCW-1:0] WORD_LAST  = BCW'(WORD_BITS-1);

  logic [BW-1:0]          baud_cnt_r;
  logic                   tick_s;
  logic                   rx_meta_r, rx_sync_r, rx_prev_r;

  rx_state_t              rx_state_r;
  logic [TCW-1:0]         rx_tick_cnt_r;
  logic [BCW-1:0]         rx_bit_cnt_r;
  logic [WORD_BITS-1:0]   rx_shift_r;
  logic                   rx_par_r;
  logic [WORD_BITS-1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_err_r, parity_err_r, overrun_r;

  tx_state_t              tx_state_r;
  logic [TCW-1:0]         tx_tick_cnt_r;
  logic [BCW-1:0]         tx_bit_cnt_r;
  logic [WORD_BITS-1:0]   tx_shift_r;
  logic                   tx_par_r;
  logic                   tx_r, tx_busy_r;

  logic                   fifo_wr_s, fifo_rd_s, fifo_full_s, fifo_empty_s;
  logic [WORD_BITS-1:0]   fifo_rdata_s;

  assign tick_s    = (baud_cnt_r == BAUD_LAST);
  assign fifo_wr_s = rx_valid_r & echo_en_i;
  assign fifo_rd_s = (tx_state_r == TX_IDLE) & ~fifo_empty_s & tx_en_i;

  // Free-running baud tick divider.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                  baud_cnt_r <= '0;
    else if (baud_cnt_r == BAUD_LAST) baud_cnt_r <= '0;
    else                          baud_cnt_r <= baud_cnt_r + 1'b1;
  end

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver FSM; clear is written first so a same-cycle error event overrides it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state_r    <= RX_IDLE;
      rx_tick_cnt_r <= '0;
      rx_bit_cnt_r  <= '0;
      rx_shift_r    <= '0;
      rx_par_r      <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      parity_err_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (clear_err_i) begin
        frame_err_r  <= 1'b0;
        parity_err_r <= 1'b0;
      end
      case (rx_state_r)
        RX_IDLE: begin
          rx_tick_cnt_r <= '0;
          rx_bit_cnt_r  <= '0;
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (tick_s) begin
            if (rx_tick_cnt_r == HALF_LAST) begin
              rx_tick_cnt_r <= '0;
              rx_state_r    <= rx_sync_r ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_cnt_r <= rx_tick_cnt_r + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick_s) begin
            if (rx_tick_cnt_r == BIT_LAST) begin
              rx_tick_cnt_r <= '0;
              rx_shift_r    <= {rx_sync_r, rx_shift_r[WORD_BITS-1:1]};
              rx_bit_cnt_r  <= rx_bit_cnt_r + 1'b1;
              if (rx_bit_cnt_r == WORD_LAST) rx_state_r <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              rx_tick_cnt_r <= rx_tick_cnt_r + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (tick_s) begin
            if (rx_tick_cnt_r == BIT_LAST) begin
              rx_tick_cnt_r <= '0;
              rx_par_r      <= rx_sync_r;
              rx_state_r    <= RX_STOP;
            end else begin
              rx_tick_cnt_r <= rx_tick_cnt_r + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick_s) begin
            if (rx_tick_cnt_r == BIT_LAST) begin
              rx_tick_cnt_r <= '0;
              rx_state_r    <= RX_IDLE;
              if (!rx_sync_r) begin
                frame_err_r <= 1'b1;
              end else if (HAS_PARITY && (rx_par_r != word_parity(9'(rx_shift_r), PAR_MODE))) begin
                parity_err_r <= 1'b1;
              end else begin
                rx_data_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
              end
            end else begin
              rx_tick_cnt_r <= rx_tick_cnt_r + 1'b1;
            end
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Overrun: fullness is judged before any same-cycle pop, so the word is dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                      overrun_r <= 1'b0;
    else if (fifo_wr_s && fifo_full_s) overrun_r <= 1'b1;
    else if (clear_err_i)             overrun_r <= 1'b0;
    else                              overrun_r <= overrun_r;
  end

  uart_sync_fifo #(
    .WORD_BITS      (WORD_BITS),
    .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .write   (fifo_wr_s),
    .read    (fifo_rd_s),
    .wdata   (rx_data_r),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_o)
  );

  // Transmitter FSM; the start bit spans one extra tick so later bits align to the tick grid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_r    <= TX_IDLE;
      tx_tick_cnt_r <= '0;
      tx_bit_cnt_r  <= '0;
      tx_shift_r    <= '0;
      tx_par_r      <= 1'b0;
      tx_r          <= 1'b1;
      tx_busy_r     <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_tick_cnt_r <= '0;
          tx_bit_cnt_r  <= '0;
          tx_r          <= 1'b1;
          tx_busy_r     <= 1'b0;
          if (fifo_rd_s) begin
            tx_shift_r <= fifo_rdata_s;
            tx_par_r   <= word_parity(9'(fifo_rdata_s), PAR_MODE);
            tx_r       <= 1'b0;
            tx_busy_r  <= 1'b1;
            tx_state_r <= TX_START;
          end
        end
        TX_START: begin
          if (tick_s) begin
            if (tx_tick_cnt_r == START_LAST) begin
              tx_tick_cnt_r <= '0;
              tx_r          <= tx_shift_r[0];
              tx_shift_r    <= {1'b0, tx_shift_r[WORD_BITS-1:1]};
              tx_state_r    <= TX_DATA;
            end else begin
              tx_tick_cnt_r <= tx_tick_cnt_r + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (tick_s) begin
            if (tx_tick_cnt_r == BIT_LAST) begin
              tx_tick_cnt_r <= '0;
              tx_bit_cnt_r  <= tx_bit_cnt_r + 1'b1;
              if (tx_bit_cnt_r == WORD_LAST) begin
                tx_r       <= HAS_PARITY ? tx_par_r : 1'b1;
                tx_state_r <= HAS_PARITY ? TX_PARITY : TX_STOP;
              end else begin
                tx_r       <= tx_shift_r[0];
                tx_shift_r <= {1'b0, tx_shift_r[WORD_BITS-1:1]};
              end
            end else begin
              tx_tick_cnt_r <= tx_tick_cnt_r + 1'b1;
            end
          end
        end
        TX_PARITY: begin
          if (tick_s) begin
            if (tx_tick_cnt_r == BIT_LAST) begin
              tx_tick_cnt_r <= '0;
              tx_r          <= 1'b1;
              tx_state_r    <= TX_STOP;
            end else begin
              tx_tick_cnt_r <= tx_tick_cnt_r + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (tick_s) begin
            if (tx_tick_cnt_r == STOP_LAST) begin
              tx_tick_cnt_r <= '0;
              tx_busy_r     <= 1'b0;
              tx_state_r    <= TX_IDLE;
            end else begin
              tx_tick_cnt_r <= tx_tick_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          tx_r       <= 1'b1;
          tx_busy_r  <= 1'b0;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_o         = tx_r;
  assign tx_busy_o    = tx_busy_r;
  assign rx_data_o    = rx_data_r;
  assign rx_valid_o   = rx_valid_r;
  assign overrun_o    = overrun_r;
  assign frame_err_o  = frame_err_r;
  assign parity_err_o = parity_err_r;

endmodule

// File: tb/tb_uart_echo_core.sv
// tb_uart_echo_core: drives serial frames into uart_echo_core, decodes the echoed
// line independently and compares both against a frame-level reference model.
module tb_uart_echo_core;

  localparam int W       = 8;
  localparam int OS      = 16;
  localparam int BD      = 4;
  localparam int AB      = 4;
  localparam int PODD    = 1;
  localparam int DEPTH   = 1 << AB;
  localparam int BIT_CLK = OS * BD;
`ifdef UART_ECHO_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  typedef logic [W-1:0] wq_t[$];

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          rx_i = 1'b1;
  logic          echo_en_i = 1'b1;
  logic          tx_en_i = 1'b1;
  logic          clear_err_i = 1'b0;
  logic          tx_o, rx_valid_o, tx_busy_o, overrun_o, frame_err_o, parity_err_o;
  logic [W-1:0]  rx_data_o;
  logic [AB:0]   fifo_level_o;

  int errors = 0;
  int checks = 0;
  int rst_epoch = 0;
  wq_t rx_obs, tx_obs;

  uart_echo_core #(
    .WORD_BITS(W), .OVERSAMPLE(OS), .BAUD_DIV(BD), .STOP_BITS(1),
    .FIFO_ADDR_BITS(AB), .PARITY_ODD(PODD)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .tx_o(tx_o),
    .echo_en_i(echo_en_i), .tx_en_i(tx_en_i), .clear_err_i(clear_err_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .tx_busy_o(tx_busy_o),
    .fifo_level_o(fifo_level_o), .overrun_o(overrun_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Parity bit that brings the frame's total count of ones to the configured sense.
  function automatic logic model_parity(input logic [W-1:0] d);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) != (PODD != 0);
  endfunction

  always @(posedge reset_i) rst_epoch++;

  always @(negedge clk) begin
    if (!reset_i && rx_valid_o) rx_obs.push_back(rx_data_o);
  end

  // Line decoder: centre-samples each bit relative to the falling start edge.
  initial begin : tx_mon
    logic [W-1:0] w;
    logic st, sp, pb;
    int ep;
    forever begin
      @(negedge tx_o);
      ep = rst_epoch;
      pb = 1'b0;
      repeat (BIT_CLK/2) @(posedge clk);
      #1 st = tx_o;
      repeat (BIT_CLK + 2) @(posedge clk);
      #1 w[0] = tx_o;
      for (int k = 1; k < W; k++) begin
        repeat (BIT_CLK) @(posedge clk);
        #1 w[k] = tx_o;
      end
      if (PBITS != 0) begin
        repeat (BIT_CLK) @(posedge clk);
        #1 pb = tx_o;
      end
      repeat (BIT_CLK) @(posedge clk);
      #1 sp = tx_o;
      if (ep == rst_epoch && !reset_i) begin
        check("tx_start_bit", st, 1'b0);
        check("tx_stop_bit", sp, 1'b1);
`ifdef UART_ECHO_PARITY_EN
        check("tx_parity_bit", pb, model_parity(w));
`endif
        tx_obs.push_back(w);
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop_v, input logic pbit);
    @(negedge clk);
    send_bit(1'b0);
    for (int k = 0; k < W; k++) send_bit(d[k]);
    if (PBITS != 0) send_bit(pbit);
    send_bit(stop_v);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((fifo_level_o != '0 || tx_busy_o) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_in_time"}, (n < 40000), 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_q(input string tag, input wq_t obs, input wq_t exp);
    check({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++) check({tag, "_word"}, obs[i], exp[i]);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    wq_t exp_rx, exp_tx, model_q;
    logic [W-1:0] d;
    logic model_ovr;
    int n;

    repeat (3) @(negedge clk);
    check("rst_tx_o", tx_o, 1'b1);
    check("rst_tx_busy", tx_busy_o, 1'b0);
    check("rst_level", fifo_level_o, 0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_errs", {overrun_o, frame_err_o, parity_err_o}, 3'b000);
    reset_i = 1'b0;
    repeat (5) @(negedge clk);

    // Basic echo of 0xA5.
    send_frame(8'hA5, 1'b1, model_parity(8'hA5));
    wait_drain("echo");
    exp_rx = {8'hA5};
    cmp_q("echo_rx", rx_obs, exp_rx);
    cmp_q("echo_tx", tx_obs, exp_rx);
    check("echo_level", fifo_level_o, 0);
    rx_obs.delete(); tx_obs.delete();

    // Random words with random echo enable.
    exp_rx.delete(); exp_tx.delete();
    for (int i = 0; i < 12; i++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      echo_en_i = 1'($urandom_range(0, 1));
      send_frame(d, 1'b1, model_parity(d));
      exp_rx.push_back(d);
      if (echo_en_i) exp_tx.push_back(d);
    end
    echo_en_i = 1'b1;
    wait_drain("rand");
    cmp_q("rand_rx", rx_obs, exp_rx);
    cmp_q("rand_tx", tx_obs, exp_tx);
    check("rand_errs", {overrun_o, frame_err_o, parity_err_o}, 3'b000);
    rx_obs.delete(); tx_obs.delete();

    // Framing error: stop bit low.
    send_frame(8'h3C, 1'b0, model_parity(8'h3C));
    repeat (2 * BIT_CLK) @(negedge clk);
    check("ferr_flag", frame_err_o, 1'b1);
    check("ferr_no_valid", rx_obs.size(), 0);
    check("ferr_no_tx", {tx_busy_o, tx_o}, 2'b01);
    check("ferr_tx_frames", tx_obs.size(), 0);
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    @(negedge clk);
    check("ferr_cleared", frame_err_o, 1'b0);

    // Glitch shorter than half a bit.
    rx_i = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("glitch_no_valid", rx_obs.size(), 0);
    check("glitch_no_errs", {overrun_o, frame_err_o, parity_err_o}, 3'b000);
    check("glitch_level", fifo_level_o, 0);

    // Overrun: 17 words into a 16-deep queue with the transmitter held off.
    tx_en_i = 1'b0;
    model_q.delete(); model_ovr = 1'b0; exp_rx.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      d = W'(i);
      send_frame(d, 1'b1, model_parity(d));
      exp_rx.push_back(d);
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else model_ovr = 1'b1;
    end
    repeat (10) @(negedge clk);
    check("ovr_level", fifo_level_o, model_q.size());
    check("ovr_flag", overrun_o, model_ovr);
    check("ovr_tx_idle", tx_busy_o, 1'b0);
    cmp_q("ovr_rx", rx_obs, exp_rx);
    tx_en_i = 1'b1;
    wait_drain("ovr");
    cmp_q("ovr_tx", tx_obs, model_q);
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun_o, 1'b0);
    rx_obs.delete(); tx_obs.delete();

`ifdef UART_ECHO_PARITY_EN
    // Parity: correct bit accepted and echoed, wrong bit rejected.
    send_frame(8'h01, 1'b1, model_parity(8'h01));
    wait_drain("par_ok");
    exp_rx = {8'h01};
    cmp_q("par_ok_rx", rx_obs, exp_rx);
    cmp_q("par_ok_tx", tx_obs, exp_rx);
    check("par_ok_flag", parity_err_o, 1'b0);
    rx_obs.delete(); tx_obs.delete();
    send_frame(8'h01, 1'b1, ~model_parity(8'h01));
    repeat (2 * BIT_CLK) @(negedge clk);
    check("par_bad_flag", parity_err_o, 1'b1);
    check("par_bad_rx", rx_obs.size(), 0);
    check("par_bad_tx", tx_obs.size(), 0);
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    @(negedge clk);
    check("par_cleared", parity_err_o, 1'b0);
`endif

    // Reset in the middle of a transmitted word with more queued.
    tx_en_i = 1'b0;
    send_frame(8'h11, 1'b1, model_parity(8'h11));
    send_frame(8'h22, 1'b1, model_parity(8'h22));
    send_frame(8'h33, 1'b1, model_parity(8'h33));
    repeat (4) @(negedge clk);
    check("mid_level", fifo_level_o, 3);
    tx_en_i = 1'b1;
    n = 0;
    while (!tx_busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_tx_started", tx_busy_o, 1'b1);
    repeat (3 * BIT_CLK) @(negedge clk);
    reset_i = 1'b1;
    #1;
    check("mid_rst_tx_o", tx_o, 1'b1);
    check("mid_rst_busy", tx_busy_o, 1'b0);
    check("mid_rst_level", fifo_level_o, 0);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    tx_obs.delete();
    repeat (30 * BIT_CLK) @(negedge clk);
    check("post_rst_frames", tx_obs.size(), 0);
    check("post_rst_line", {tx_busy_o, tx_o}, 2'b01);
    check("post_rst_level", fifo_level_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_echo_core.md
# uart_echo_core

Self-contained, parametrised UART echo engine: integrated oversampling baud divider, receiver, elastic FIFO and transmitter. Received words can be looped back through the FIFO to the serial output. Adds over the previous echo design:
- configurable word width, stop bits and FIFO depth;
- optional parity;
- transmit flow control;
- sticky error reporting.

Sits directly on the board UART pins; host-side logic observes received words and status.

## Interface
Parameters:
- WORD_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, baud ticks per bit, even, ≥8
- BAUD_DIV, 651, clk_i cycles per baud tick, ≥2
- STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first
- FIFO_ADDR_BITS, 4, FIFO depth = 2^FIFO_ADDR_BITS
- PARITY_ODD, 0, 1 = odd, 0 = even; only meaningful with UART_ECHO_PARITY_EN

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial in, asynchronous, idle high
- tx_o  out  1  serial out, idle high
- echo_en_i  in  1  1 = enqueue valid received words
- tx_en_i  in  1  1 = transmitter may start a new word
- clear_err_i  in  1  clears sticky error flags
- rx_data_o  out  WORD_BITS  last valid received word
- rx_valid_o  out  1  one-cycle pulse per valid word
- tx_busy_o  out  1  transmitter not IDLE
- fifo_level_o  out  FIFO_ADDR_BITS+1  words queued, 0..2^FIFO_ADDR_BITS
- overrun_o, frame_err_o, parity_err_o  out  1 each  sticky error flags

## Operation
- **Baud divider:** counter 0..BAUD_DIV-1, free-running from reset. The tick is a one-cycle pulse on the terminal count.
- **Input sync:** rx_i passes through a 2-FF synchroniser; both flops reset to 1.
- **RX FSM (IDLE, START, DATA, PARITY, STOP):**
  - IDLE→START on a synchronised 1→0.
  - START: after OVERSAMPLE/2 ticks, line low → DATA; line high → IDLE (glitch rejected, no error).
  - DATA: samples every OVERSAMPLE ticks, LSB first, WORD_BITS samples.
  - PARITY: one sample; state skipped without macro.
  - STOP: one sample, then IDLE on the same cycle. Back-to-back frames are accepted.
- **Stop sample result:**
  - stop = 0 → frame_err_o set, word discarded.
  - Parity mismatch → parity_err_o set, word discarded.
  - Otherwise: rx_data_o loads, rx_valid_o pulses.
  - If echo_en_i = 1: FIFO write. If the FIFO is full (full evaluated before any same-cycle read), the word is dropped and overrun_o is set.
- **TX FSM (IDLE, START, DATA, PARITY, STOP):**
  - IDLE with FIFO non-empty and tx_en_i = 1 → pop the head into the shift register, enter START.
  - START: 1 bit; DATA: LSB first; PARITY: skipped without macro.
  - STOP: STOP_BITS × OVERSAMPLE ticks, then IDLE.
  - tx_en_i low only blocks new starts; a word in flight completes.
- **echo_en_i = 0:** words are still reported on rx_valid_o but not queued. Queued words still drain.
- **FIFO:** simultaneous read and write both succeed and the level is unchanged. Pointers wrap modulo depth; level uses FIFO_ADDR_BITS+1 bits.
- **Error flags:** clear_err_i clears all three. If an error event and clear occur in the same cycle, set wins.
- **Reset (any time, mid-frame included):**
  - FSMs → IDLE; FIFO emptied.
  - tx_o = 1 and tx_busy_o = 0, both immediately.
  - rx_data_o = 0, rx_valid_o = 0, level = 0, error flags = 0.

## Timing
- Bit period: exactly OVERSAMPLE × BAUD_DIV clk_i cycles.
- RX start confirmation: OVERSAMPLE/2 ticks after the falling edge is seen at the synchroniser output (2-cycle sync delay).
- FIFO write: rx_valid_o and the write occur in the same cycle, 1 clk after the stop-sample tick. fifo_level_o updates the following cycle.
- TX start: IDLE with the start condition true in cycle N → pop in cycle N. tx_o falls and tx_busy_o rises at N+1.
- TX bit boundaries: counted from the first baud tick after N+1. The start bit may therefore last up to one extra tick; all later bits are exact.
- All outputs are registered.

## Configuration
- UART_ECHO_PARITY_EN **defined:**
  - RX and TX include one parity bit after the data bits.
  - Parity type per PARITY_ODD.
  - parity_err_o is functional.
- UART_ECHO_PARITY_EN **undefined:**
  - No parity bit on the line; PARITY states unreachable.
  - parity_err_o tied to 0.

## Structure
- Package uart_echo_pkg:
  - rx/tx state enum typedefs;
  - parity mode constants;
  - function computing parity over WORD_BITS.
- One sub-module: uart_sync_fifo.
  - Parameters WORD_BITS, FIFO_ADDR_BITS.
  - Ports: write, read, wdata, rdata, full, empty, level.
  - Head word visible combinationally on rdata; read advances.
- Baud divider, RX FSM and TX FSM are inline in uart_echo_core.

## Test plan
- **Basic echo:** BAUD_DIV=4, OVERSAMPLE=16, drive 0xA5 8N1 at 64 clk/bit → rx_valid_o pulses once with rx_data_o=0xA5; tx_o emits frame 0,1,0,1,0,0,1,0,1,1; level returns to 0.
- **Framing error:** frame 0x3C with stop bit 0 → frame_err_o=1, no rx_valid_o, tx_o stays 1. clear_err_i pulse → 0.
- **Overrun:** tx_en_i=0, 17 back-to-back bytes 0x00..0x10 → level 16, overrun_o=1. tx_en_i=1 → 0x00..0x0F echoed in order; 0x10 absent.
- **Glitch rejection:** rx_i low for 3 OVERSAMPLE ticks then high → no rx_valid_o, no error flags.
- **Parity (macro defined, PARITY_ODD=1):** 0x01 with parity 0 → accepted and echoed with parity 0. Same word with parity 1 → parity_err_o=1, not echoed.
- **Reset mid-transmit:** assert reset_i during TX DATA with 3 words queued → tx_o=1 same cycle, level 0, tx_busy_o=0. No further frames after release.
